macc_out_quant: RTL and testbench

- Downstream consumer of the MAC accumulator stage.
- Counts accumulator beats per output pixel and captures the final sum of each kernel window.
- Rounds, right-shifts, optionally applies ReLU and saturates the sum to OUT_W bits.
- Buffers results in a small FIFO with valid/ready output, drives the MAC's accumulator-clear pulse, and backpressures the MAC when buffer space runs out.

---
 rtl/macc_pkg.sv | 34 +++
 rtl/macc_out_quant_if.sv | 28 ++
 rtl/macc_out_quant_fifo.sv | 65 ++++++
 rtl/macc_out_quant.sv | 121 ++++++++++++
 tb/tb_macc_out_quant.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/macc_pkg.sv
// Shared widths and the round / shift / saturate arithmetic for the MAC output quantizer.
// Helpers work on 64-bit signed values so any ACC_W up to 62 bits rounds without wrap.
package macc_pkg;

  localparam int ACC_W_DEF      = 40;
  localparam int OUT_W_DEF      = 16;
  localparam int LEN_W_DEF      = 12;
  localparam int SHIFT_W_DEF    = 6;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Round half up, then arithmetic shift right.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                     input int unsigned sh);
    logic signed [63:0] r;
    r = acc;
    if (sh != 0) r = r + (64'sd1 <<< (sh - 1));
    return r >>> sh;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    if (v > sat_hi(w)) return sat_hi(w);
    if (v < sat_lo(w)) return sat_lo(w);
    return v;
  endfunction

endpackage

// File: rtl/macc_out_quant_if.sv
// Accumulator-in / quantized-out handshake bundle.
// The DUT uses the slave side; the upstream MAC and the output consumer are the master side.
interface macc_out_quant_if
  import macc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) ();

  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc_data;
  logic                    acc_ready;
  logic                    acc_clr;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ready;

  modport master (
    output acc_valid, acc_data, out_ready,
    input  acc_ready, acc_clr, out_valid, out_data
  );

  modport slave (
    input  acc_valid, acc_data, out_ready,
    output acc_ready, acc_clr, out_valid, out_data
  );

endinterface

// File: rtl/macc_out_quant_fifo.sv
// First-word-fall-through FIFO: pop_data/valid show the head entry, zero when empty.
// A push while full is accepted only together with a pop.
module sync_fifo_fwft #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid    = (count_q != '0);
  assign pop_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH)) && !pop));

endmodule

// File: rtl/macc_out_quant.sv
// Counts MAC beats per kernel window, captures the final sum, rounds/shifts, applies ReLU,
// saturates to OUT_W and buffers results; acc_ready reserves FIFO space for in-flight results.
module macc_out_quant
  import macc_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int SHIFT_W    = SHIFT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEN_W-1:0]   cfg_kernel_len,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_relu_en,
  macc_out_quant_if.slave    bus,
  output logic               sat_sticky
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [LEN_W-1:0]        cnt_q, cnt_d, len_eff;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [ACC_W-1:0] s1_acc_q, s1_acc_d;
  logic [SHIFT_W-1:0]      s1_shift_q, s1_shift_d;
  logic                    s1_relu_q, s1_relu_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [ACC_W:0]   s2_val_q, s2_val_d;
  logic                    s2_relu_q, s2_relu_d;
  logic                    acc_clr_q, acc_clr_d;
  logic                    sat_sticky_q, sat_sticky_d;

  logic [CNT_W-1:0]        fifo_count;
  logic [OCC_W-1:0]        occ;
  logic                    acc_ready, accept, final_beat, clamp;
  logic signed [63:0]      rnd64, v64, q64;
  logic [OUT_W-1:0]        fifo_head;
  logic                    fifo_valid;
  logic                    unused_rnd_hi;

  always_comb begin
    len_eff    = (cfg_kernel_len == '0) ? LEN_W'(1) : cfg_kernel_len;
    occ        = OCC_W'(fifo_count) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
    acc_ready  = rst_n && (occ < OCC_W'(FIFO_DEPTH));
    accept     = bus.acc_valid && acc_ready;
    final_beat = accept && (cnt_q == len_eff - LEN_W'(1));

    cnt_d = cnt_q;
    if (accept) cnt_d = final_beat ? '0 : cnt_q + LEN_W'(1);

    // Shift and ReLU mode travel with the captured sum.
    s1_valid_d = final_beat;
    s1_acc_d   = final_beat ? bus.acc_data : s1_acc_q;
    s1_shift_d = final_beat ? cfg_shift    : s1_shift_q;
    s1_relu_d  = final_beat ? cfg_relu_en  : s1_relu_q;

    rnd64      = round_shift({{(64-ACC_W){s1_acc_q[ACC_W-1]}}, s1_acc_q}, 32'(s1_shift_q));
    s2_valid_d = s1_valid_q;
    s2_val_d   = s1_valid_q ? rnd64[ACC_W:0] : s2_val_q;
    s2_relu_d  = s1_valid_q ? s1_relu_q : s2_relu_q;

    v64 = {{(63-ACC_W){s2_val_q[ACC_W]}}, s2_val_q};
    if (s2_relu_q && (v64 < 0)) v64 = '0;
    q64   = saturate(v64, OUT_W);
    clamp = (q64 != v64);

    acc_clr_d    = final_beat;
    sat_sticky_d = sat_sticky_q | (s2_valid_q & clamp);
  end

  assign unused_rnd_hi = ^rnd64[63:ACC_W+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_acc_q     <= '0;
      s1_shift_q   <= '0;
      s1_relu_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_val_q     <= '0;
      s2_relu_q    <= 1'b0;
      acc_clr_q    <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_acc_q     <= s1_acc_d;
      s1_shift_q   <= s1_shift_d;
      s1_relu_q    <= s1_relu_d;
      s2_valid_q   <= s2_valid_d;
      s2_val_q     <= s2_val_d;
      s2_relu_q    <= s2_relu_d;
      acc_clr_q    <= acc_clr_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s2_valid_q),
    .push_data (q64[OUT_W-1:0]),
    .pop       (fifo_valid && bus.out_ready),
    .pop_data  (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.acc_ready = acc_ready;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_head;
  assign sat_sticky    = sat_sticky_q;

endmodule

// File: tb/tb_macc_out_quant.sv
// Directed and randomized bench for macc_out_quant; every output pop is checked
// against a behavioural quantizer model in addition to the hand-computed directed values.
module tb_macc_out_quant;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] cfg_kernel_len;
  logic [5:0]  cfg_shift;
  logic        cfg_relu_en;
  logic        sat_sticky;

  int     n_cmp = 0;
  int     n_err = 0;
  longint exp_q[$];
  int     m_cnt = 0, n_fin = 0, n_clr = 0, n_pop = 0, n_acc = 0;
  bit     rand_done;

  always #5 clk = ~clk;

  macc_out_quant_if #(.ACC_W(40), .OUT_W(16)) bus ();

  macc_out_quant dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_kernel_len (cfg_kernel_len),
    .cfg_shift      (cfg_shift),
    .cfg_relu_en    (cfg_relu_en),
    .bus            (bus),
    .sat_sticky     (sat_sticky)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint quant(input logic signed [39:0] d, input int sh, input bit relu);
    longint a;
    a = d;
    if (sh > 0) a = a + (longint'(1) << (sh - 1));
    a = a >>> sh;
    if (relu && a < 0) a = 0;
    if (a > 32767) a = 32767;
    else if (a < -32768) a = -32768;
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [39:0] d);
    bit ok;
    int g;
    bus.acc_valid = 1'b1;
    bus.acc_data  = d;
    ok = 1'b0;
    g  = 0;
    while (!ok && g < 200) begin
      @(negedge clk);
      ok = bus.acc_ready;
      step();
      g++;
    end
    if (!ok) check("beat_timeout", 0, 1);
    bus.acc_valid = 1'b0;
  endtask

  // Monitor and reference model, sampled mid-cycle so handshakes reflect the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (bus.acc_clr) n_clr++;
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        check("out_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("stream", bus.out_data, exp_q.pop_front());
      end
      if (bus.acc_valid && bus.acc_ready) begin
        n_acc++;
        m_cnt++;
        if (m_cnt >= ((cfg_kernel_len == 0) ? 1 : int'(cfg_kernel_len))) begin
          m_cnt = 0;
          n_fin++;
          exp_q.push_back(quant(bus.acc_data, int'(cfg_shift), cfg_relu_en));
        end
      end
    end
  end

  initial begin
    int a0, p0, c0, g;
    logic [63:0] r;
    bus.acc_valid  = 1'b0;
    bus.acc_data   = '0;
    bus.out_ready  = 1'b1;
    cfg_kernel_len = 12'd1;
    cfg_shift      = 6'd0;
    cfg_relu_en    = 1'b0;

    repeat (2) step();
    check("rst_ready_low", bus.acc_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", bus.acc_ready, 1);
    check("post_rst_valid", bus.out_valid, 0);
    check("post_rst_data", bus.out_data, 0);
    check("post_rst_clr", bus.acc_clr, 0);
    check("post_rst_sticky", sat_sticky, 0);

    // Basic quantize: (40+8)>>>4 = 3
    cfg_kernel_len = 12'd3;
    cfg_shift      = 6'd4;
    beat(10);
    beat(20);
    check("basic_noclr", bus.acc_clr, 0);
    beat(40);
    check("basic_clr", bus.acc_clr, 1);
    check("basic_early", bus.out_valid, 0);
    step();
    check("basic_clr_once", bus.acc_clr, 0);
    check("basic_n2", bus.out_valid, 0);
    step();
    check("basic_valid", bus.out_valid, 1);
    check("basic_data", bus.out_data, 3);
    step();
    check("basic_popped", bus.out_valid, 0);

    // Rounding of a negative value, then ReLU
    cfg_kernel_len = 12'd1;
    cfg_shift      = 6'd2;
    beat(-6);
    step();
    step();
    check("neg_valid", bus.out_valid, 1);
    check("neg_data", bus.out_data, -1);
    cfg_relu_en = 1'b1;
    beat(-6);
    step();
    step();
    check("relu_data", bus.out_data, 0);
    check("relu_nosat", sat_sticky, 0);

    // Saturation both ways
    cfg_relu_en = 1'b0;
    cfg_shift   = 6'd0;
    beat(40'sd65536);
    step();
    check("sat_not_yet", sat_sticky, 0);
    step();
    check("sat_hi_data", bus.out_data, 32767);
    check("sat_sticky", sat_sticky, 1);
    beat(-40'sd70000);
    step();
    step();
    check("sat_lo_data", bus.out_data, -32768);

    // Backpressure: four results fill the buffer, the fifth beat must wait
    step();
    bus.out_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 4; i++) beat(40'(100 + i));
    check("bp_ready_low", bus.acc_ready, 0);
    bus.acc_valid = 1'b1;
    bus.acc_data  = 40'sd104;
    a0 = n_acc;
    repeat (10) step();
    check("bp_held", n_acc - a0, 0);
    check("bp_still_low", bus.acc_ready, 0);
    check("bp_head_valid", bus.out_valid, 1);
    check("bp_head_data", bus.out_data, 100);
    bus.out_ready = 1'b1;
    for (int i = 4; i < 10; i++) beat(40'(100 + i));
    repeat (6) step();
    check("bp_drained", exp_q.size(), 0);
    check("bp_count", n_pop - p0, 10);
    check("sticky_hold", sat_sticky, 1);

    // Random windows with random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          cfg_kernel_len = 12'($urandom_range(0, 5));
          cfg_shift      = 6'($urandom_range(0, 39));
          cfg_relu_en    = 1'($urandom_range(0, 1));
          for (int b = 0; b < ((cfg_kernel_len == 0) ? 1 : int'(cfg_kernel_len)); b++) begin
            r = {$urandom, $urandom};
            beat(r[39:0]);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      step();
      g++;
    end
    check("rand_drain", exp_q.size(), 0);

    // Reset in the middle of a window discards it
    step();
    cfg_kernel_len = 12'd8;
    cfg_shift      = 6'd0;
    cfg_relu_en    = 1'b0;
    c0 = n_clr;
    p0 = n_pop;
    for (int i = 0; i < 5; i++) beat(40'(i + 1));
    rst_n = 1'b0;
    step();
    check("rstw_ready_low", bus.acc_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rstw_sticky_clr", sat_sticky, 0);
    check("rstw_no_out", bus.out_valid, 0);
    check("rstw_no_clr", n_clr - c0, 0);
    for (int i = 0; i < 8; i++) beat(40'(10 + i));
    step();
    step();
    check("rstw_valid", bus.out_valid, 1);
    check("rstw_data", bus.out_data, 17);
    step();
    check("rstw_clr", n_clr - c0, 1);
    check("rstw_pops", n_pop - p0, 1);
    check("clr_total", n_clr, n_fin);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
